dds_amp_ramp: RTL and testbench

- Sits directly downstream of the DDS parameter controller, on the amplitude path, ahead of the RFDC DDS core.
- Input is the controller's 14-bit unsigned target amplitude. Output is an amplitude that slews linearly toward the target instead of stepping.
- The slew rate is set by a programmable step size and step interval.
- Runs entirely in the CLK100MHZ domain.

---
 rtl/dds_ramp_pkg.sv | 13 +
 rtl/dds_ramp_prescaler.sv | 36 +++
 rtl/dds_amp_ramp.sv | 125 ++++++++++++
 tb/tb_dds_amp_ramp.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/dds_ramp_pkg.sv
// Shared state encoding and default widths for the DDS amplitude ramp block.
package dds_ramp_pkg;

    localparam int DEF_AMP_WIDTH      = 14;
    localparam int DEF_INTERVAL_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RAMP_UP   = 2'd1,
        RAMP_DOWN = 2'd2
    } ramp_state_t;

endpackage

// File: rtl/dds_ramp_prescaler.sv
// Loadable down-counter that paces amplitude steps; a reload value of 0 behaves as 1.
module dds_ramp_prescaler #(
    parameter int WIDTH = 16
) (
    input  logic             CLK100MHZ,
    input  logic             reset,
    input  logic             load,
    input  logic             enable,
    input  logic [WIDTH-1:0] reload_val,
    output logic             expire
);

    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] reload_eff;

    // Period N is realised as a count of N-1 down to 0.
    assign reload_eff = (reload_val == '0) ? '0 : reload_val - WIDTH'(1);

    // A load in the same cycle as terminal count suppresses the expiry.
    assign expire = enable && !load && (count == '0);

    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= reload_eff;
        end else if (enable) begin
            if (count == '0) begin
                count <= reload_eff;
            end else begin
                count <= count - WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/dds_amp_ramp.sv
// Slews the DDS amplitude linearly toward the controller's target.
// Optional bypass input is compiled in with DDS_AMP_RAMP_BYPASS_EN.
//
// state     | meaning
// IDLE      | amp_out holds, waiting for a target change
// RAMP_UP   | stepping amp_out upward toward target_q
// RAMP_DOWN | stepping amp_out downward toward target_q
module dds_amp_ramp
    import dds_ramp_pkg::*;
#(
    parameter int AMP_WIDTH      = DEF_AMP_WIDTH,
    parameter int INTERVAL_WIDTH = DEF_INTERVAL_WIDTH
) (
    input  logic                      CLK100MHZ,
    input  logic                      reset,
    input  logic [AMP_WIDTH-1:0]      target_amp,
    input  logic [AMP_WIDTH-1:0]      step_size,
    input  logic [INTERVAL_WIDTH-1:0] step_interval,
`ifdef DDS_AMP_RAMP_BYPASS_EN
    input  logic                      ramp_bypass,
`endif
    output logic [AMP_WIDTH-1:0]      amp_out,
    output logic                      ramp_busy,
    output logic                      ramp_done
);

    ramp_state_t          state;
    logic [AMP_WIDTH-1:0] target_q;
    logic                 bypass;
    logic                 retarget;
    logic                 step_expire;

    logic [AMP_WIDTH:0]   amp_ext;
    logic [AMP_WIDTH:0]   step_ext;
    logic [AMP_WIDTH:0]   tgt_ext;
    logic [AMP_WIDTH:0]   sum_up;
    logic [AMP_WIDTH:0]   diff_dn;
    logic                 reach_up;
    logic                 reach_dn;
    logic                 step_reached;
    logic [AMP_WIDTH-1:0] step_next;

`ifdef DDS_AMP_RAMP_BYPASS_EN
    assign bypass = ramp_bypass;
`else
    assign bypass = 1'b0;
`endif

    assign retarget = !bypass && (target_amp != target_q);

    // One extra bit so overshoot past full scale or below zero is visible before clamping.
    assign amp_ext  = {1'b0, amp_out};
    assign step_ext = {1'b0, step_size};
    assign tgt_ext  = {1'b0, target_q};
    assign sum_up   = amp_ext + step_ext;
    assign diff_dn  = amp_ext - step_ext;

    assign reach_up     = (step_size == '0) || (sum_up >= tgt_ext);
    assign reach_dn     = (step_size == '0) || diff_dn[AMP_WIDTH] || (diff_dn <= tgt_ext);
    assign step_reached = (state == RAMP_UP) ? reach_up : reach_dn;
    assign step_next    = (state == RAMP_UP) ? sum_up[AMP_WIDTH-1:0] : diff_dn[AMP_WIDTH-1:0];

    dds_ramp_prescaler #(
        .WIDTH(INTERVAL_WIDTH)
    ) u_prescaler (
        .CLK100MHZ (CLK100MHZ),
        .reset     (reset),
        .load      (retarget),
        .enable    (state != IDLE),
        .reload_val(step_interval),
        .expire    (step_expire)
    );

    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            state     <= IDLE;
            target_q  <= '0;
            amp_out   <= '0;
            ramp_busy <= 1'b0;
            ramp_done <= 1'b0;
        end else begin
            ramp_done <= 1'b0;
            if (bypass) begin
                // Tracking target_q here leaves no retarget pending when bypass drops.
                target_q  <= target_amp;
                amp_out   <= target_amp;
                state     <= IDLE;
                ramp_busy <= 1'b0;
            end else if (retarget) begin
                target_q <= target_amp;
                if ((step_size == '0) || (amp_out == target_amp)) begin
                    amp_out   <= target_amp;
                    ramp_done <= 1'b1;
                    ramp_busy <= 1'b0;
                    state     <= IDLE;
                end else if (target_amp > amp_out) begin
                    state     <= RAMP_UP;
                    ramp_busy <= 1'b1;
                end else begin
                    state     <= RAMP_DOWN;
                    ramp_busy <= 1'b1;
                end
            end else begin
                case (state)
                    RAMP_UP, RAMP_DOWN: begin
                        if (step_expire) begin
                            if (step_reached) begin
                                amp_out   <= target_q;
                                ramp_done <= 1'b1;
                                ramp_busy <= 1'b0;
                                state     <= IDLE;
                            end else begin
                                amp_out <= step_next;
                            end
                        end
                    end
                    default: begin
                        ramp_busy <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dds_amp_ramp.sv
// Directed self-checking bench for dds_amp_ramp.
module tb_dds_amp_ramp;

    logic        CLK100MHZ;
    logic        reset;
    logic [13:0] target_amp;
    logic [13:0] step_size;
    logic [15:0] step_interval;
    logic [13:0] amp_out;
    logic        ramp_busy;
    logic        ramp_done;
`ifdef DDS_AMP_RAMP_BYPASS_EN
    logic        ramp_bypass;
`endif

    int n_vec = 0;
    int n_err = 0;

    dds_amp_ramp dut (
        .CLK100MHZ    (CLK100MHZ),
        .reset        (reset),
        .target_amp   (target_amp),
        .step_size    (step_size),
        .step_interval(step_interval),
`ifdef DDS_AMP_RAMP_BYPASS_EN
        .ramp_bypass  (ramp_bypass),
`endif
        .amp_out      (amp_out),
        .ramp_busy    (ramp_busy),
        .ramp_done    (ramp_done)
    );

    initial CLK100MHZ = 1'b0;
    always #5 CLK100MHZ = ~CLK100MHZ;

    task automatic tick();
        @(posedge CLK100MHZ);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk3(input string tag, input int a, input int b, input int d);
        chk({tag, ".amp"}, 32'(amp_out), 32'(a));
        chk({tag, ".busy"}, 32'(ramp_busy), 32'(b));
        chk({tag, ".done"}, 32'(ramp_done), 32'(d));
    endtask

    initial begin
`ifdef DDS_AMP_RAMP_BYPASS_EN
        ramp_bypass = 1'b0;
`endif
        reset = 1'b1;
        target_amp = '0;
        step_size = '0;
        step_interval = '0;
        tick();
        tick();
        chk3("reset", 0, 0, 0);
        reset = 1'b0;
        tick();
        chk3("post_reset", 0, 0, 0);

        // Upward ramp 0 -> 1000, step 100, interval 4.
        target_amp = 14'd1000;
        step_size = 14'd100;
        step_interval = 16'd4;
        tick();
        chk3("up_retarget", 0, 1, 0);
        for (int k = 1; k <= 10; k++) begin
            for (int c = 1; c <= 4; c++) begin
                tick();
                if (c < 4) chk3("up_hold", (k - 1) * 100, 1, 0);
                else       chk3("up_step", k * 100, (k == 10) ? 0 : 1, (k == 10) ? 1 : 0);
            end
        end
        tick();
        chk3("up_after", 1000, 0, 0);
        tick();
        chk3("up_after2", 1000, 0, 0);

        // Downward ramp 1000 -> 50, step 300, interval 1, clamp at the end.
        target_amp = 14'd50;
        step_size = 14'd300;
        step_interval = 16'd1;
        tick();
        chk3("dn_retarget", 1000, 1, 0);
        tick();
        chk3("dn_700", 700, 1, 0);
        tick();
        chk3("dn_400", 400, 1, 0);
        tick();
        chk3("dn_100", 100, 1, 0);
        tick();
        chk3("dn_50", 50, 0, 1);
        tick();
        chk3("dn_after", 50, 0, 0);

        // Mid-ramp retarget: 0 -> 2000 step 100 interval 2, turn back to 200 at 500.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk3("mid_reset", 0, 0, 0);
        target_amp = 14'd2000;
        step_size = 14'd100;
        step_interval = 16'd2;
        tick();
        chk3("mid_retarget", 0, 1, 0);
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk3("mid_up_hold", (k - 1) * 100, 1, 0);
            tick();
            chk3("mid_up_step", k * 100, 1, 0);
        end
        target_amp = 14'd200;
        tick();
        chk3("mid_turn", 500, 1, 0);
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk3("mid_dn_hold", 600 - k * 100, 1, 0);
            tick();
            chk3("mid_dn_step", 500 - k * 100, (k == 3) ? 0 : 1, (k == 3) ? 1 : 0);
        end
        tick();
        chk3("mid_after", 200, 0, 0);

        // Immediate jump with step 0.
        step_size = 14'd0;
        target_amp = 14'd12345;
        tick();
        chk3("jump", 12345, 0, 1);
        tick();
        chk3("jump_after", 12345, 0, 0);

        // Top clamp: 16000 -> 16383 with step 1000, interval 3.
        target_amp = 14'd16000;
        tick();
        chk3("top_preset", 16000, 0, 1);
        target_amp = 14'd16383;
        step_size = 14'd1000;
        step_interval = 16'd3;
        tick();
        chk3("top_retarget", 16000, 1, 0);
        tick();
        chk3("top_hold1", 16000, 1, 0);
        tick();
        chk3("top_hold2", 16000, 1, 0);
        tick();
        chk3("top_clamp", 16383, 0, 1);
        tick();
        chk3("top_after", 16383, 0, 0);

        // Reset in the middle of a downward ramp.
        target_amp = 14'd0;
        step_size = 14'd100;
        step_interval = 16'd1;
        tick();
        chk3("rst_retarget", 16383, 1, 0);
        tick();
        chk3("rst_step1", 16283, 1, 0);
        tick();
        chk3("rst_step2", 16183, 1, 0);
        reset = 1'b1;
        tick();
        chk3("rst_abort", 0, 0, 0);
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk3("rst_quiet", 0, 0, 0);
        end

        // Interval 0 behaves as 1.
        target_amp = 14'd300;
        step_size = 14'd100;
        step_interval = 16'd0;
        tick();
        chk3("iv0_retarget", 0, 1, 0);
        tick();
        chk3("iv0_100", 100, 1, 0);
        tick();
        chk3("iv0_200", 200, 1, 0);
        tick();
        chk3("iv0_300", 300, 0, 1);
        tick();
        chk3("iv0_after", 300, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
